// File: rtl/xup_74ls_pkg.sv
//------------------------------------------------------------------------------
// Module      : xup_74ls_pkg
// Description : Shared types, modulus constants and terminal-count helper for
//               the 74-series counter blocks.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package xup_74ls_pkg;

    localparam int MOD_DECADE = 10;
    localparam int MOD_BINARY = 16;

    typedef logic [3:0] nibble_t;

    function automatic nibble_t terminal_count(input int modulus, input logic up);
        terminal_count = up ? nibble_t'(modulus - 1) : nibble_t'(0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/counter_next_state.sv
//------------------------------------------------------------------------------
// Module      : counter_next_state
// Description : Combinational next-Q for the 74LS16x counter: load, count or
//               hold. Down counting is built only with XUP_74LS16X_UPDOWN_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module counter_next_state
    import xup_74ls_pkg::*;
#(
    parameter int MODULUS = MOD_BINARY
) (
    input  logic    [3:0] q_i,
    input  logic    [3:0] d_i,
    input  logic          load_n_i,
    input  logic          enp_i,
    input  logic          ent_i,
`ifdef XUP_74LS16X_UPDOWN_EN
    input  logic          up_i,
`endif
    output nibble_t       q_next_o
);

    localparam nibble_t c_LAST = nibble_t'(MODULUS - 1);

    nibble_t w_count;

    always_comb begin
        w_count = q_i + 4'd1;
        // States above the last legal count exist only in decade mode after a load.
        if (q_i > c_LAST) begin
            w_count = 4'd0;
        end
`ifdef XUP_74LS16X_UPDOWN_EN
        else if (!up_i) begin
            w_count = (q_i == 4'd0) ? c_LAST : (q_i - 4'd1);
        end
`endif
        else if (q_i == c_LAST) begin
            w_count = 4'd0;
        end
    end

    always_comb begin
        q_next_o = q_i;
        if (!load_n_i) begin
            q_next_o = d_i;
        end else if (enp_i && ent_i) begin
            q_next_o = w_count;
        end
    end

endmodule

`default_nettype wire

// File: rtl/sync_4bit_counter.sv
//------------------------------------------------------------------------------
// Module      : sync_4bit_counter
// Description : Synchronous 4-bit presettable counter (74LS160/161 style) with
//               asynchronous clear and combinational ripple carry.
//               Optional macro XUP_74LS16X_UPDOWN_EN adds the U_D port.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sync_4bit_counter
    import xup_74ls_pkg::*;
#(
    parameter int Delay   = 0,
    parameter int MODULUS = MOD_BINARY
) (
    input  logic       CLK,
    input  logic       CLR_N,
    input  logic       LOAD_N,
    input  logic       ENP,
    input  logic       ENT,
    input  logic [3:0] D,
`ifdef XUP_74LS16X_UPDOWN_EN
    input  logic       U_D,
`endif
    output logic [3:0] Q,
    output logic       RCO
);

    generate
        if (MODULUS != MOD_DECADE && MODULUS != MOD_BINARY) begin : g_bad_modulus
            $error("sync_4bit_counter: MODULUS must be 10 or 16");
        end
        if (Delay < 0) begin : g_bad_delay
            $error("sync_4bit_counter: Delay must be non-negative");
        end
    endgenerate

    nibble_t q_q;
    nibble_t q_d;
    logic    w_up;

`ifdef XUP_74LS16X_UPDOWN_EN
    assign w_up = U_D;
`else
    assign w_up = 1'b1;
`endif

    counter_next_state #(
        .MODULUS (MODULUS)
    ) u_next (
        .q_i      (q_q),
        .d_i      (D),
        .load_n_i (LOAD_N),
        .enp_i    (ENP),
        .ent_i    (ENT),
`ifdef XUP_74LS16X_UPDOWN_EN
        .up_i     (w_up),
`endif
        .q_next_o (q_d)
    );

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            q_q <= 4'h0;
        end else begin
            q_q <= q_d;
        end
    end

    // Carry is purely combinational so a cascade ripples within one clock.
    assign Q   = q_q;
    assign RCO = ENT & (q_q == terminal_count(MODULUS, w_up));

endmodule

`default_nettype wire

// File: tb/tb_sync_4bit_counter.sv
//------------------------------------------------------------------------------
// Module      : tb_sync_4bit_counter
// Description : Scoreboard bench: binary, decade and two-stage cascaded decade
//               counters; down-count cases with XUP_74LS16X_UPDOWN_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sync_4bit_counter;

    typedef struct {
        string      name;
        int         dut;
        logic [3:0] q;
        logic       rco;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    event sample_ev;

    logic clk = 1'b0;
    logic clr_n;
    logic bin_load_n, bin_enp, bin_ent;
    logic [3:0] bin_d, bin_q;
    logic bin_rco;
    logic dec_load_n, dec_enp, dec_ent;
    logic [3:0] dec_d, dec_q;
    logic dec_rco;
    logic casc_enp, casc_ent;
    logic [3:0] lo_q, hi_q;
    logic lo_rco, hi_rco;
`ifdef XUP_74LS16X_UPDOWN_EN
    logic ud;
`endif

    always #5 clk = ~clk;

    sync_4bit_counter #(.Delay(0), .MODULUS(16)) u_bin (
        .CLK(clk), .CLR_N(clr_n), .LOAD_N(bin_load_n), .ENP(bin_enp), .ENT(bin_ent),
        .D(bin_d),
`ifdef XUP_74LS16X_UPDOWN_EN
        .U_D(1'b1),
`endif
        .Q(bin_q), .RCO(bin_rco)
    );

    sync_4bit_counter #(.Delay(0), .MODULUS(10)) u_dec (
        .CLK(clk), .CLR_N(clr_n), .LOAD_N(dec_load_n), .ENP(dec_enp), .ENT(dec_ent),
        .D(dec_d),
`ifdef XUP_74LS16X_UPDOWN_EN
        .U_D(ud),
`endif
        .Q(dec_q), .RCO(dec_rco)
    );

    sync_4bit_counter #(.Delay(0), .MODULUS(10)) u_lo (
        .CLK(clk), .CLR_N(clr_n), .LOAD_N(1'b1), .ENP(casc_enp), .ENT(casc_ent),
        .D(4'h0),
`ifdef XUP_74LS16X_UPDOWN_EN
        .U_D(1'b1),
`endif
        .Q(lo_q), .RCO(lo_rco)
    );

    sync_4bit_counter #(.Delay(0), .MODULUS(10)) u_hi (
        .CLK(clk), .CLR_N(clr_n), .LOAD_N(1'b1), .ENP(casc_enp), .ENT(lo_rco),
        .D(4'h0),
`ifdef XUP_74LS16X_UPDOWN_EN
        .U_D(1'b1),
`endif
        .Q(hi_q), .RCO(hi_rco)
    );

    task automatic push(input string n, input int dut, input logic [3:0] q, input logic rco);
        exp_t e;
        e.name = n; e.dut = dut; e.q = q; e.rco = rco;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    // Monitor: drains the scoreboard on each falling edge or on an async sample request.
    initial begin
        forever begin
            @(negedge clk or sample_ev);
            while (sb.size() > 0) begin
                exp_t e;
                logic [3:0] aq;
                logic       ar;
                e = sb.pop_front();
                case (e.dut)
                    0:       begin aq = bin_q; ar = bin_rco; end
                    1:       begin aq = dec_q; ar = dec_rco; end
                    2:       begin aq = lo_q;  ar = lo_rco;  end
                    default: begin aq = hi_q;  ar = hi_rco;  end
                endcase
                checks++;
                if (aq !== e.q || ar !== e.rco) begin
                    errors++;
                    $display("FAIL %s: got Q=%0d RCO=%b, expected Q=%0d RCO=%b",
                             e.name, aq, ar, e.q, e.rco);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clr_n = 1'b0;
        bin_load_n = 1'b1; bin_enp = 1'b0; bin_ent = 1'b1; bin_d = 4'h0;
        dec_load_n = 1'b1; dec_enp = 1'b0; dec_ent = 1'b1; dec_d = 4'h0;
        casc_enp = 1'b0; casc_ent = 1'b0;
`ifdef XUP_74LS16X_UPDOWN_EN
        ud = 1'b1;
`endif
        #2;
        push("reset_bin", 0, 4'd0, 1'b0);
        push("reset_dec", 1, 4'd0, 1'b0);
        -> sample_ev;
        settle();
        clr_n = 1'b1;

        // Binary count: 0..15 then wrap to 0..3
        bin_enp = 1'b1;
        for (int i = 1; i < 20; i++) begin
            tick();
            push($sformatf("bin_count_%0d", i), 0, 4'(i % 16), (i % 16) == 15);
            settle();
        end
        bin_enp = 1'b0;

        // Decade: load illegal 12, then count 0..9 and wrap
        dec_load_n = 1'b0; dec_d = 4'd12; dec_enp = 1'b1;
        tick();
        push("dec_load12", 1, 4'd12, 1'b0);
        settle();
        dec_load_n = 1'b1;
        for (int i = 0; i < 11; i++) begin
            tick();
            push($sformatf("dec_count_%0d", i), 1, 4'(i % 10), (i % 10) == 9);
            settle();
        end
        dec_enp = 1'b0;

        // Asynchronous clear between edges while counting from 7
        bin_load_n = 1'b0; bin_d = 4'd7;
        tick();
        push("bin_load7", 0, 4'd7, 1'b0);
        settle();
        bin_load_n = 1'b1; bin_enp = 1'b1;
        clr_n = 1'b0;
        #1;
        push("async_clear", 0, 4'd0, 1'b0);
        -> sample_ev;
        #1;
        clr_n = 1'b1;
        tick();
        push("after_clear", 0, 4'd1, 1'b0);
        settle();
        bin_enp = 1'b0;

        // Clear beats load at the same edge
        clr_n = 1'b0; bin_load_n = 1'b0; bin_d = 4'd9;
        tick();
        push("clear_over_load", 0, 4'd0, 1'b0);
        settle();
        clr_n = 1'b1; bin_load_n = 1'b1;

        // Load ignores enables; ENT low holds and masks RCO
        bin_load_n = 1'b0; bin_d = 4'd5; bin_enp = 1'b0; bin_ent = 1'b1;
        tick();
        push("load5_enp0", 0, 4'd5, 1'b0);
        settle();
        bin_load_n = 1'b1; bin_enp = 1'b1; bin_ent = 1'b0;
        tick();
        push("hold_ent0", 0, 4'd5, 1'b0);
        settle();
        bin_ent = 1'b1;
        tick();
        push("count_ent1", 0, 4'd6, 1'b0);
        settle();

        // ENT falling at terminal drops RCO without a clock
        bin_load_n = 1'b0; bin_d = 4'd15; bin_enp = 1'b0;
        tick();
        push("load15_rco", 0, 4'd15, 1'b1);
        settle();
        bin_load_n = 1'b1; bin_ent = 1'b0;
        #1;
        push("ent_drop_rco", 0, 4'd15, 1'b0);
        -> sample_ev;
        settle();
        bin_ent = 1'b1;

        // Two cascaded decades: 00..99 then 00
        casc_enp = 1'b1; casc_ent = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            int n;
            n = i % 100;
            tick();
            push($sformatf("casc_lo_%0d", i), 2, 4'(n % 10), (n % 10) == 9);
            push($sformatf("casc_hi_%0d", i), 3, 4'(n / 10), n == 99);
            settle();
        end
        casc_enp = 1'b0;

`ifdef XUP_74LS16X_UPDOWN_EN
        // Decade down count from 2 through the 0 -> 9 wrap
        ud = 1'b0;
        dec_load_n = 1'b0; dec_d = 4'd2; dec_enp = 1'b1; dec_ent = 1'b1;
        tick();
        push("down_load2", 1, 4'd2, 1'b0);
        settle();
        dec_load_n = 1'b1;
        tick(); push("down_1", 1, 4'd1, 1'b0); settle();
        tick(); push("down_0", 1, 4'd0, 1'b1); settle();
        tick(); push("down_9", 1, 4'd9, 1'b0); settle();
        ud = 1'b1;
        #1;
        push("ud_rco_follow", 1, 4'd9, 1'b1);
        -> sample_ev;
        #1;
        ud = 1'b0;
        tick(); push("down_8", 1, 4'd8, 1'b0); settle();

        // Illegal decade state goes to 0 even when counting down
        dec_load_n = 1'b0; dec_d = 4'd13;
        tick(); push("down_load13", 1, 4'd13, 1'b0); settle();
        dec_load_n = 1'b1;
        tick(); push("down_illegal", 1, 4'd0, 1'b1); settle();
        dec_enp = 1'b0;
`endif

        settle();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
